pcs_block_sync: RTL and testbench

Per-lane receive block synchroniser for the 10GBASE-R / 40GBASE-R PCS receive path. It sits between the SERDES gearbox and the descrambler/lane-deskew logic inside the receive PCS, one instance per lane. It inspects the 2-bit sync header of every 66b block and pulses gearbox slip requests until header alignment is found. It reports per-lane block lock and, optionally, a high bit-error-rate condition.

---
 rtl/pcs_block_sync_if.sv | 27 ++
 rtl/pcs_block_sync.sv | 211 +++++++++++++++++++++
 tb/tb_pcs_block_sync.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pcs_block_sync_if.sv
// Lane-side bundle between the SERDES gearbox and the per-lane block synchroniser.
// slave: the synchroniser; master: the gearbox/driver side.
interface pcs_block_sync_if #(
    parameter int HEAD_W = 2
);
    logic              serdes_v_i;
    logic [HEAD_W-1:0] serdes_head_i;
    logic              gearbox_slip_o;
    logic              lock_o;
    logic              hi_ber_o;

    modport slave (
        input  serdes_v_i,
        input  serdes_head_i,
        output gearbox_slip_o,
        output lock_o,
        output hi_ber_o
    );

    modport master (
        output serdes_v_i,
        output serdes_head_i,
        input  gearbox_slip_o,
        input  lock_o,
        input  hi_ber_o
    );
endinterface

// File: rtl/pcs_block_sync.sv
// Per-lane 66b block synchroniser: hunts for sync-header alignment with gearbox slips and reports lock.
// Optional hi-BER monitor is built when PCS_BLOCK_SYNC_HIBER_EN is defined; otherwise hi_ber_o is 0.
module pcs_block_sync #(
    parameter int HEAD_W      = 2,
    parameter int SH_CNT_N    = 64,
    parameter int SH_INVLD_N  = 16,
    parameter int SLIP_WAIT_N = 4,
    parameter int BER_WIN_N   = 19531,
    parameter int BER_BAD_N   = 16
) (
    input  logic               clk,
    input  logic               nreset,
    pcs_block_sync_if.slave    lane
);
    localparam int SH_W   = $clog2(SH_CNT_N + 1);
    localparam int INV_W  = $clog2(SH_INVLD_N + 1);
    localparam int SLIP_W = $clog2(SLIP_WAIT_N + 1);

    typedef enum logic [1:0] {
        UNLOCK    = 2'd0,
        LOCK      = 2'd1,
        SLIP_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SH_W-1:0]    r_sh_cnt;
    logic [SH_W-1:0]    w_sh_cnt_nxt;
    logic [INV_W-1:0]   r_inv_cnt;
    logic [INV_W-1:0]   w_inv_cnt_nxt;
    logic [SLIP_W-1:0]  r_slip_cnt;
    logic [SLIP_W-1:0]  w_slip_cnt_nxt;
    logic               r_slip;
    logic               w_slip_nxt;
    logic               r_lock;
    logic               w_lock_nxt;

    logic               w_valid;
    logic               w_head_ok;
    logic [SH_W-1:0]    w_sh_inc;
    logic [INV_W-1:0]   w_inv_inc;
    logic [SLIP_W-1:0]  w_slip_inc;
    logic               w_sh_full;
    logic               w_inv_full;
    logic               w_slip_done;

    // Nothing in the BER path can work with a degenerate window or threshold.
    if (BER_WIN_N < 1 || BER_BAD_N < 1 || BER_BAD_N > BER_WIN_N || SLIP_WAIT_N < 1) begin : g_bad_cfg
        logic w_cfg_error;
        assign w_cfg_error = 1'b1;
    end

    assign w_valid     = lane.serdes_v_i;
    assign w_head_ok   = (lane.serdes_head_i == HEAD_W'(1)) || (lane.serdes_head_i == HEAD_W'(2));
    assign w_sh_inc    = r_sh_cnt + 1'b1;
    assign w_inv_inc   = r_inv_cnt + {{(INV_W-1){1'b0}}, ~w_head_ok};
    assign w_slip_inc  = r_slip_cnt + 1'b1;
    assign w_sh_full   = (w_sh_inc == SH_W'(SH_CNT_N));
    assign w_inv_full  = (w_inv_inc == INV_W'(SH_INVLD_N));
    assign w_slip_done = (w_slip_inc == SLIP_W'(SLIP_WAIT_N));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= UNLOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_valid) begin
            case (r_state)
                UNLOCK: begin
                    if (!w_head_ok) begin
                        w_state_nxt = SLIP_WAIT;
                    end else if (w_sh_full) begin
                        w_state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (w_inv_full) begin
                        w_state_nxt = SLIP_WAIT;
                    end
                end
                SLIP_WAIT: begin
                    if (w_slip_done) begin
                        w_state_nxt = UNLOCK;
                    end
                end
                default: w_state_nxt = UNLOCK;
            endcase
        end
    end

    // Invalid-count check wins over window completion so a window-closing 16th error still drops lock.
    always_comb begin
        w_slip_nxt     = 1'b0;
        w_lock_nxt     = r_lock;
        w_sh_cnt_nxt   = r_sh_cnt;
        w_inv_cnt_nxt  = r_inv_cnt;
        w_slip_cnt_nxt = r_slip_cnt;
        if (w_valid) begin
            case (r_state)
                UNLOCK: begin
                    if (!w_head_ok) begin
                        w_slip_nxt     = 1'b1;
                        w_sh_cnt_nxt   = '0;
                        w_inv_cnt_nxt  = '0;
                        w_slip_cnt_nxt = '0;
                    end else if (w_sh_full) begin
                        w_lock_nxt    = 1'b1;
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt = w_sh_inc;
                    end
                end
                LOCK: begin
                    if (w_inv_full) begin
                        w_lock_nxt     = 1'b0;
                        w_slip_nxt     = 1'b1;
                        w_sh_cnt_nxt   = '0;
                        w_inv_cnt_nxt  = '0;
                        w_slip_cnt_nxt = '0;
                    end else if (w_sh_full) begin
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt  = w_sh_inc;
                        w_inv_cnt_nxt = w_inv_inc;
                    end
                end
                SLIP_WAIT: begin
                    w_slip_cnt_nxt = w_slip_done ? '0 : w_slip_inc;
                end
                default: begin
                    w_lock_nxt     = 1'b0;
                    w_sh_cnt_nxt   = '0;
                    w_inv_cnt_nxt  = '0;
                    w_slip_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_slip     <= 1'b0;
            r_lock     <= 1'b0;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_slip_cnt <= '0;
        end else begin
            r_slip     <= w_slip_nxt;
            r_lock     <= w_lock_nxt;
            r_sh_cnt   <= w_sh_cnt_nxt;
            r_inv_cnt  <= w_inv_cnt_nxt;
            r_slip_cnt <= w_slip_cnt_nxt;
        end
    end

    assign lane.gearbox_slip_o = r_slip;
    assign lane.lock_o         = r_lock;

`ifdef PCS_BLOCK_SYNC_HIBER_EN
    localparam int WIN_W = $clog2(BER_WIN_N + 1);
    localparam int BAD_W = $clog2(BER_BAD_N + 1);

    logic [WIN_W-1:0] r_ber_win;
    logic [BAD_W-1:0] r_ber_bad;
    logic             r_hi_ber;
    logic [WIN_W-1:0] w_ber_win_inc;
    logic [BAD_W-1:0] w_ber_bad_nxt;
    logic             w_ber_win_end;
    logic             w_ber_bad_full;

    assign w_ber_win_inc  = r_ber_win + 1'b1;
    assign w_ber_win_end  = (w_ber_win_inc == WIN_W'(BER_WIN_N));
    assign w_ber_bad_nxt  = (!w_head_ok && (r_ber_bad != BAD_W'(BER_BAD_N))) ? r_ber_bad + 1'b1 : r_ber_bad;
    assign w_ber_bad_full = (w_ber_bad_nxt == BAD_W'(BER_BAD_N));

    // Monitor runs only while locked; the block that loses lock wipes the window.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_ber_win <= '0;
            r_ber_bad <= '0;
            r_hi_ber  <= 1'b0;
        end else if (w_valid && r_lock) begin
            if (!w_lock_nxt) begin
                r_ber_win <= '0;
                r_ber_bad <= '0;
                r_hi_ber  <= 1'b0;
            end else begin
                if (w_ber_bad_full) begin
                    r_hi_ber <= 1'b1;
                end else if (w_ber_win_end) begin
                    r_hi_ber <= 1'b0;
                end
                r_ber_win <= w_ber_win_end ? '0 : w_ber_win_inc;
                r_ber_bad <= w_ber_win_end ? '0 : w_ber_bad_nxt;
            end
        end
    end

    assign lane.hi_ber_o = r_hi_ber;
`else
    assign lane.hi_ber_o = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_block_sync.sv
// Directed and randomized bench for pcs_block_sync against a block-level behavioural model.
// Expects hi_ber activity only when PCS_BLOCK_SYNC_HIBER_EN is defined.
module tb_pcs_block_sync;
    localparam int SH_CNT_N    = 64;
    localparam int SH_INVLD_N  = 16;
    localparam int SLIP_WAIT_N = 4;
    localparam int BER_WIN_N   = 100;
    localparam int BER_BAD_N   = 4;
`ifdef PCS_BLOCK_SYNC_HIBER_EN
    localparam bit BER_EN = 1'b1;
`else
    localparam bit BER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    string curTest = "init";

    // Model state, expressed as "blocks still to ignore", "good run length" and window tallies.
    bit mLocked, mSlip, mHiBer;
    int mRun, mIgnore, mWinBlk, mWinBad, mBerBlk, mBerBad;

    always #5 clk = ~clk;

    pcs_block_sync_if #(.HEAD_W(2)) lane ();

    pcs_block_sync #(
        .HEAD_W      (2),
        .SH_CNT_N    (SH_CNT_N),
        .SH_INVLD_N  (SH_INVLD_N),
        .SLIP_WAIT_N (SLIP_WAIT_N),
        .BER_WIN_N   (BER_WIN_N),
        .BER_BAD_N   (BER_BAD_N)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .lane   (lane)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%b expected=%b", curTest, tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mLocked = 0; mSlip = 0; mHiBer = 0;
        mRun = 0; mIgnore = 0; mWinBlk = 0; mWinBad = 0; mBerBlk = 0; mBerBad = 0;
    endtask

    task automatic modelStep(input bit v, input logic [1:0] h);
        bit good;
        bit wasLocked;
        good = (h == 2'b01) || (h == 2'b10);
        wasLocked = mLocked;
        mSlip = 0;
        if (v) begin
            if (mIgnore > 0) begin
                mIgnore--;
            end else if (!mLocked) begin
                if (good) begin
                    mRun++;
                    if (mRun == SH_CNT_N) begin
                        mLocked = 1; mRun = 0; mWinBlk = 0; mWinBad = 0;
                    end
                end else begin
                    mSlip = 1; mRun = 0; mIgnore = SLIP_WAIT_N;
                end
            end else begin
                mWinBlk++;
                if (!good) mWinBad++;
                if (mWinBad == SH_INVLD_N) begin
                    mLocked = 0; mSlip = 1; mIgnore = SLIP_WAIT_N; mRun = 0;
                    mWinBlk = 0; mWinBad = 0;
                end else if (mWinBlk == SH_CNT_N) begin
                    mWinBlk = 0; mWinBad = 0;
                end
            end
            if (wasLocked && !mLocked) begin
                mBerBlk = 0; mBerBad = 0; mHiBer = 0;
            end else if (wasLocked) begin
                mBerBlk++;
                if (!good && mBerBad < BER_BAD_N) mBerBad++;
                if (mBerBad == BER_BAD_N) mHiBer = 1;
                if (mBerBlk == BER_WIN_N) begin
                    if (mBerBad < BER_BAD_N) mHiBer = 0;
                    mBerBlk = 0; mBerBad = 0;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("slip", lane.gearbox_slip_o, mSlip);
        checkOutput("lock", lane.lock_o, mLocked);
        checkOutput("hiBer", lane.hi_ber_o, BER_EN ? mHiBer : 1'b0);
    endtask

    task automatic applyStimulus(input bit v, input logic [1:0] h);
        lane.serdes_v_i    = v;
        lane.serdes_head_i = h;
        @(posedge clk);
        #1;
        modelStep(v, h);
        checkAll();
    endtask

    // Reset is held with a valid invalid-header block present to show reset dominates.
    task automatic applyReset(input int n);
        nreset = 1'b0;
        lane.serdes_v_i    = 1'b1;
        lane.serdes_head_i = 2'b11;
        repeat (n) @(posedge clk);
        #1;
        modelReset();
        checkOutput("rstSlip", lane.gearbox_slip_o, 1'b0);
        checkOutput("rstLock", lane.lock_o, 1'b0);
        checkOutput("rstHiBer", lane.hi_ber_o, 1'b0);
        nreset = 1'b1;
    endtask

    function automatic logic [1:0] randHead(input int badPermille);
        if ($urandom_range(999) < badPermille) return ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
        return ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        int rates[4];
        lane.serdes_v_i    = 1'b0;
        lane.serdes_head_i = 2'b00;
        modelReset();

        curTest = "reset";
        applyReset(2);

        curTest = "acquire";
        repeat (SH_CNT_N - 1) applyStimulus(1'b1, 2'b01);
        checkOutput("notYet", lane.lock_o, 1'b0);
        applyStimulus(1'b1, 2'b01);
        checkOutput("locked", lane.lock_o, 1'b1);

        curTest = "slip";
        applyReset(1);
        repeat (10) applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b11);
        checkOutput("pulse", lane.gearbox_slip_o, 1'b1);
        repeat (SLIP_WAIT_N) applyStimulus(1'b1, 2'b00);
        checkOutput("pulseEnds", lane.gearbox_slip_o, 1'b0);
        repeat (SH_CNT_N - 1) applyStimulus(1'b1, 2'b10);
        checkOutput("notYet", lane.lock_o, 1'b0);
        applyStimulus(1'b1, 2'b10);
        checkOutput("relocked", lane.lock_o, 1'b1);

        curTest = "window15";
        for (int i = 0; i < SH_CNT_N; i++)
            applyStimulus(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b10);
        checkOutput("held", lane.lock_o, 1'b1);

        curTest = "window16";
        for (int i = 0; i <= 60; i++)
            applyStimulus(1'b1, (i % 4 == 0) ? 2'b11 : 2'b01);
        checkOutput("lost", lane.lock_o, 1'b0);
        checkOutput("slipAtLoss", lane.gearbox_slip_o, 1'b1);

        curTest = "gated";
        repeat (SLIP_WAIT_N + SH_CNT_N) applyStimulus(1'b1, 2'b01);
        checkOutput("relocked", lane.lock_o, 1'b1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 2'b01);
            applyStimulus(1'b0, 2'b11);
        end
        repeat (SH_INVLD_N - 1) applyStimulus(1'b1, 2'b00);
        checkOutput("stillLocked", lane.lock_o, 1'b1);

        curTest = "resetInSlipWait";
        applyStimulus(1'b1, 2'b00);
        checkOutput("slip", lane.gearbox_slip_o, 1'b1);
        repeat (2) applyStimulus(1'b1, 2'b00);
        applyReset(1);
        repeat (SH_CNT_N - 1) applyStimulus(1'b1, 2'b01);
        checkOutput("notYet", lane.lock_o, 1'b0);
        applyStimulus(1'b1, 2'b01);
        checkOutput("locked", lane.lock_o, 1'b1);

        curTest = "hiBer";
        for (int i = 0; i < BER_WIN_N; i++)
            applyStimulus(1'b1, (i == 10 || i == 30 || i == 50 || i == 70) ? 2'b00 : 2'b01);
        checkOutput("set", lane.hi_ber_o, BER_EN);
        repeat (BER_WIN_N - 1) applyStimulus(1'b1, 2'b10);
        checkOutput("heldToWinEnd", lane.hi_ber_o, BER_EN);
        applyStimulus(1'b1, 2'b10);
        checkOutput("cleared", lane.hi_ber_o, 1'b0);

        curTest = "random";
        rates = '{5, 30, 200, 2};
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(499) == 0) applyReset(1);
                else applyStimulus($urandom_range(9) < 8, randHead(rates[p]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
